// File: rtl/sub_sequencer_pkg.sv
// Shared types and widths for the subtractor sequencer.
package sub_sequencer_pkg;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NEG    = 3'd1,
    ADD_LO = 3'd2,
    ADD_HI = 3'd3,
    DONE   = 3'd4
  } state_t;
endpackage

// File: rtl/sub_sequencer_nibble_add_step.sv
// Combinational 4-bit add with carry-in/carry-out; shared by both nibble cycles.
module sub_sequencer_nibble_add_step (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};
endmodule

// File: rtl/sub_sequencer.sv
// A - B control stage: requests -B from the negation stage, then adds A to it
// over two nibble cycles; level-sensitive en/ready toward its own requester.
module sub_sequencer
  import sub_sequencer_pkg::*;
#(
  parameter int NEG_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              neg_en,
  output logic [DATA_W-1:0] neg_operand,
  input  logic [DATA_W-1:0] neg_result,
  input  logic              neg_ready,
  output logic [DATA_W-1:0] Output,
  output logic              ready,
  output logic              borrow,
  output logic              zero,
  output logic              overflow,
  output logic              err
);
  localparam logic [7:0] TMO = 8'(NEG_TIMEOUT);

  state_t            state_q;
  logic [DATA_W-1:0] a_q, b_q, nb_q, out_q;
  logic [3:0]        rlo_q;
  logic              c4_q;
  logic [7:0]        cnt_q;
  logic              ready_q, err_q, neg_en_q, borrow_q, zero_q, ovf_q;

  logic [3:0]        add_a, add_b, add_s;
  logic              add_ci, add_co;
  logic [DATA_W-1:0] sum_full;

  // One adder serves both nibbles; ADD_HI switches to the upper halves and c4.
  always_comb begin
    add_a  = a_q[3:0];
    add_b  = nb_q[3:0];
    add_ci = 1'b0;
    if (state_q == ADD_HI) begin
      add_a  = a_q[7:4];
      add_b  = nb_q[7:4];
      add_ci = c4_q;
    end
  end

  sub_sequencer_nibble_add_step u_nibble_add_step (
    .a_i (add_a),
    .b_i (add_b),
    .c_i (add_ci),
    .s_o (add_s),
    .c_o (add_co)
  );

  assign sum_full = {add_s, rlo_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      nb_q     <= '0;
      out_q    <= '0;
      rlo_q    <= '0;
      c4_q     <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      neg_en_q <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          if (en) begin
            a_q      <= A;
            b_q      <= B;
            cnt_q    <= '0;
            neg_en_q <= 1'b1;
            state_q  <= NEG;
          end
        end
        NEG: begin
          if (!en) begin
            neg_en_q <= 1'b0;
            state_q  <= IDLE;
          end else if (neg_ready) begin
            nb_q     <= neg_result;
            neg_en_q <= 1'b0;
            state_q  <= ADD_LO;
          end else if (cnt_q == TMO) begin
            neg_en_q <= 1'b0;
            err_q    <= 1'b1;
            ready_q  <= 1'b0;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ADD_LO: begin
          if (!en) begin
            state_q <= IDLE;
          end else begin
            rlo_q   <= add_s;
            c4_q    <= add_co;
            state_q <= ADD_HI;
          end
        end
        ADD_HI: begin
          if (!en) begin
            state_q <= IDLE;
          end else begin
            out_q    <= sum_full;
            ready_q  <= 1'b1;
            // B=0 negates to 0 so c8 is 0, yet there is no borrow.
            borrow_q <= (b_q != '0) & ~add_co;
            zero_q   <= (sum_full == '0);
            ovf_q    <= (a_q[7] != b_q[7]) & (add_s[3] != a_q[7]);
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (!en) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign neg_en      = neg_en_q;
  assign neg_operand = b_q;
  assign Output      = out_q;
  assign ready       = ready_q;
  assign borrow      = borrow_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign err         = err_q;
endmodule

// File: doc/sub_sequencer.md
Name: sub_sequencer

Overview:
Sequential 8-bit subtractor control stage that sits directly upstream of the two's-complement negation stage, drives it, and consumes its result. It computes Output = A - B. It first requests the negation of B through the en/ready handshake of the negation stage. It then adds A to the returned value over two nibble cycles with an internal carry, producing the result plus borrow, zero and overflow flags. It presents the same level-sensitive en/ready handshake to its own requester.

Parameters:
NEG_TIMEOUT, 15, maximum cycles to wait for neg_ready before aborting with err=1 (range 1-255)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  level request; operation runs while high, aborts when low
A  input  8  minuend, captured on the IDLE->NEG transition
B  input  8  subtrahend, captured on the IDLE->NEG transition
neg_en  output  1  enable to the negation stage
neg_operand  output  8  latched B, driven to the negation stage input
neg_result  input  8  two's complement of neg_operand from the negation stage
neg_ready  input  1  negation stage result valid
Output  output  8  A - B (mod 256), valid while ready=1
ready  output  1  result valid; held until en falls
borrow  output  1  1 when A < B unsigned
zero  output  1  1 when Output == 0
overflow  output  1  signed overflow of A - B
err  output  1  negation-stage timeout; held until en falls

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State IDLE.
  - ready, err, neg_en, borrow, zero and overflow all 0.
  - Output, neg_operand and internal registers are 8'h00.
- IDLE:
  - When en=1, latch A and B into registers, set neg_operand=B, go to NEG.
  - ready=0, err=0.
- NEG:
  - neg_en=1; a wait counter increments each cycle.
  - When neg_ready=1, latch neg_result as NB and go to ADD_LO.
  - If the counter reaches NEG_TIMEOUT first, go to DONE with err=1 and ready=0.
- ADD_LO:
  - neg_en=0.
  - Compute {c4, R[3:0]} = A[3:0] + NB[3:0], with carry-in 0.
  - Register c4 and R[3:0], then go to ADD_HI.
- ADD_HI:
  - Compute {c8, R[7:4]} = A[7:4] + NB[7:4] + c4.
  - Go to DONE.
  - On this same edge, register Output = R and set ready=1.
  - Register the flags:
    - borrow = (B != 0) & ~c8. For B = 0, c8 = 0 but borrow must be 0.
    - zero = (R == 0).
    - overflow = (A[7] != B[7]) & (R[7] != A[7]).
- DONE:
  - Hold Output, the flags, ready and err stable while en=1.
  - When en=0, clear ready and err, go to IDLE.
  - Output and flags keep their last value.
- Latency: en rise to ready = 1 (IDLE) + N (negation latency, N >= 1) + 2 (ADD_LO, ADD_HI) cycles.
- Abort: en=0 in NEG, ADD_LO or ADD_HI returns to IDLE on the next edge.
  - neg_en drops on that same edge.
  - No ready pulse; Output and flags are unchanged.
- Operand changes on A or B after capture are ignored until the next IDLE->NEG transition.
- neg_ready seen outside NEG is ignored.
- en re-asserted on the same edge DONE->IDLE is processed: IDLE captures on the following edge; a new request needs at least one cycle with en low.
- Reset mid-operation: immediate return to reset values, regardless of the clock.
- Arithmetic: all mod 256. The B = 0 case relies on the negation stage returning 8'h00; the result is then A and borrow is 0.

Decomposition:
- Shared package: the state encoding localparams (IDLE, NEG, ADD_LO, ADD_HI, DONE; 3 bits) and the width constant DATA_W = 8.
- One natural sub-module: nibble_add_step. It is a combinational 4-bit add with carry-in and carry-out, instantiated once and reused for both nibble cycles via operand muxes.
- The FSM, counter and flag logic stay in sub_sequencer.

Test Plan:
- A=9, B=5, negation stub returns 8'hFB after 2 cycles -> ready after 5 cycles; Output=8'h04, borrow=0, zero=0, overflow=0.
- A=5, B=9, stub returns 8'hF7 -> Output=8'hFC, borrow=1, zero=0, overflow=0.
- A=8'h80, B=8'h01, stub returns 8'hFF -> Output=8'h7F, overflow=1, borrow=0. Then A=B=8'h3C -> Output=0, zero=1.
- A=8'h23, B=0, stub returns 8'h00 -> Output=8'h23, borrow=0; ready held 10 cycles while en=1, cleared the cycle after en falls.
- Stub never asserts neg_ready, NEG_TIMEOUT=15 -> err=1 and ready=0 after 16 cycles in NEG; neg_en=0 in DONE; err clears when en falls.
- Abort and reset: en dropped in ADD_LO -> IDLE next edge, no ready, neg_en=0. rst_n pulsed low mid-NEG between clock edges -> all outputs 0 immediately.
